// File: rtl/apb_slave_regfile_if.sv
// apb_slave_regfile_if: APB bus bundle between the master
// and the register-file slave.
interface apb_slave_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB register file with byte strobes,
// programmable wait states and PSLVERR on bad addresses.
module apb_slave_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input logic                pclk,
  input logic                rst_n,
  apb_slave_regfile_if.slave apb
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = (NB > 1) ? $clog2(NB) : 0;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK =
    ADDR_WIDTH'((1 << LB) - 1);
  localparam logic [ADDR_WIDTH:0] NREGS =
    (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  cap;
  logic                  done;
  logic                  rdy;
  logic                  err;
  logic [ADDR_WIDTH:0]   idx;
  logic [RW-1:0]         ridx;
  logic [DATA_WIDTH-1:0] row;
  logic [DATA_WIDTH-1:0] row_d;

  // Decode works only on the captured address, so the
  // response never depends on live bus inputs.
  assign idx  = {1'b0, addr_q >> LB};
  assign ridx = idx[RW-1:0];
  assign err  = (|(addr_q & LANE_MASK)) | (idx >= NREGS);
  assign row  = regs_q[ridx];
  assign rdy  = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    row_d = row;
    for (int i = 0; i < NB; i++) begin
      if (strb_q[i]) row_d[i*8 +: 8] = wdata_q[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = SETUP;
          cap     = 1'b1;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          done = 1'b1;
          if (apb.psel && !apb.penable) begin
            state_d = SETUP;
            cap     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (apb.psel && apb.penable) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        addr_q  <= apb.paddr;
        wr_q    <= apb.pwrite;
        wdata_q <= apb.pwdata;
        strb_q  <= apb.pstrb;
      end
      if (done && wr_q && !err) regs_q[ridx] <= row_d;
    end
  end

  assign apb.pready  = rdy;
  assign apb.pslverr = rdy & err;
  assign apb.prdata  = (rdy && !wr_q && !err) ? row : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: three register files with 0, 2 and 3
// wait states, checked against a scoreboard and memory model.
module tb_apb_slave_regfile;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
  localparam int ND = 3;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0] rst_n_v;
  logic [ND-1:0] psel_v;
  logic [ND-1:0] penable_v;
  logic [ND-1:0] pwrite_v;
  logic [AW-1:0] paddr_a  [ND];
  logic [DW-1:0] pwdata_a [ND];
  logic [3:0]    pstrb_a  [ND];
  wire  [DW-1:0] prdata_a [ND];
  wire  [ND-1:0] pready_v;
  wire  [ND-1:0] pslverr_v;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_slave_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    assign bus.psel      = psel_v[g];
    assign bus.penable   = penable_v[g];
    assign bus.pwrite    = pwrite_v[g];
    assign bus.paddr     = paddr_a[g];
    assign bus.pwdata    = pwdata_a[g];
    assign bus.pstrb     = pstrb_a[g];
    assign prdata_a[g]   = bus.prdata;
    assign pready_v[g]   = bus.pready;
    assign pslverr_v[g]  = bus.pslverr;
    apb_slave_regfile #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .pclk (clk),
      .rst_n(rst_n_v[g]),
      .apb  (bus)
    );
  end

  int            n_chk = 0;
  int            n_err = 0;
  exp_t          sbq [$];
  logic [DW-1:0] model [ND][NR];

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int d, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [3:0] st, input bit chain);
    exp_t e;
    exp_t o;
    int   idx;
    int   lat;
    idx     = int'(a >> 2);
    e.err   = (a[1:0] != 2'd0) || (idx >= NR);
    e.lat   = 2 + ws_of(d);
    e.rdata = '0;
    if (!wr && !e.err) e.rdata = model[d][idx];
    if (wr && !e.err)
      for (int i = 0; i < 4; i++)
        if (st[i]) model[d][idx][i*8 +: 8] = wd[i*8 +: 8];
    sbq.push_back(e);
    psel_v[d]    = 1'b1;
    penable_v[d] = 1'b0;
    pwrite_v[d]  = wr;
    paddr_a[d]   = a;
    pwdata_a[d]  = wd;
    pstrb_a[d]   = st;
    @(posedge clk); #1;
    chk($sformatf("setup_rdy d%0d", d), 64'(pready_v[d]), 64'h0);
    penable_v[d] = 1'b1;
    pwrite_v[d]  = ~wr;
    paddr_a[d]   = ~a;
    pwdata_a[d]  = ~wd;
    pstrb_a[d]   = ~st;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!pready_v[d])
        chk($sformatf("wait_prdata d%0d", d), 64'(prdata_a[d]), 64'h0);
    end while (!pready_v[d] && lat < 40);
    o = sbq.pop_front();
    if (!pready_v[d]) begin
      chk($sformatf("timeout d%0d a%0h", d, a), 64'h0, 64'h1);
    end else begin
      chk($sformatf("lat d%0d a%0h", d, a), 64'(lat + 1), 64'(o.lat));
      chk($sformatf("pslverr d%0d a%0h", d, a),
          64'(pslverr_v[d]), 64'(o.err));
      chk($sformatf("prdata d%0d a%0h", d, a),
          64'(prdata_a[d]), 64'(o.rdata));
    end
    if (!chain) begin
      psel_v[d]    = 1'b0;
      penable_v[d] = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("rdy_1cyc d%0d", d), 64'(pready_v[d]), 64'h0);
    end
  endtask

  task automatic wr(input int d, input logic [AW-1:0] a,
                    input logic [DW-1:0] v, input logic [3:0] st,
                    input bit chain);
    xfer(d, 1'b1, a, v, st, chain);
  endtask

  task automatic rd(input int d, input logic [AW-1:0] a, input bit chain);
    xfer(d, 1'b0, a, '0, 4'h0, chain);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < NR; i++) model[d][i] = '0;
      paddr_a[d]  = '0;
      pwdata_a[d] = '0;
      pstrb_a[d]  = '0;
    end
    rst_n_v   = '0;
    psel_v    = '1;
    penable_v = '0;
    pwrite_v  = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_pready", 64'(pready_v), 64'h0);
      chk("rst_pslverr", 64'(pslverr_v), 64'h0);
      for (int d = 0; d < ND; d++)
        chk("rst_prdata", 64'(prdata_a[d]), 64'h0);
    end
    rst_n_v = '1;
    psel_v  = '0;
    @(posedge clk); #1;

    for (int d = 0; d < ND; d++) rd(d, 8'h00, 1'b0);

    wr(0, 8'h08, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd(0, 8'h08, 1'b0);
    wr(0, 8'h04, 32'h1122_3344, 4'hF, 1'b0);
    wr(0, 8'h04, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd(0, 8'h04, 1'b0);
    wr(0, 8'h04, 32'h5555_5555, 4'h0, 1'b0);
    rd(0, 8'h04, 1'b0);

    wr(0, 8'h00, 32'h0BAD_F00D, 4'hF, 1'b0);
    wr(0, 8'h40, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(0, 8'h01, 32'h1234_5678, 4'hF, 1'b0);
    rd(0, 8'h00, 1'b0);
    rd(0, 8'h02, 1'b0);
    rd(0, 8'h40, 1'b0);
    rd(0, 8'h3C, 1'b0);

    wr(2, 8'h0C, 32'hA5A5_0001, 4'hF, 1'b0);
    rd(2, 8'h0C, 1'b0);

    wr(1, 8'h0C, 32'h600D_0001, 4'hF, 1'b0);
    psel_v[1]    = 1'b1;
    penable_v[1] = 1'b0;
    pwrite_v[1]  = 1'b1;
    paddr_a[1]   = 8'h0C;
    pwdata_a[1]  = 32'hBAD0_0002;
    pstrb_a[1]   = 4'hF;
    @(posedge clk); #1;
    penable_v[1] = 1'b1;
    @(posedge clk); #1;
    chk("abort_access_rdy", 64'(pready_v[1]), 64'h0);
    penable_v[1] = 1'b0;
    psel_v[1]    = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_rdy", 64'(pready_v[1]), 64'h0);
    end
    rd(1, 8'h0C, 1'b0);

    wr(1, 8'h10, 32'h1111_0010, 4'hF, 1'b1);
    wr(1, 8'h14, 32'h2222_0014, 4'hF, 1'b1);
    wr(1, 8'h18, 32'h3333_0018, 4'hF, 1'b1);
    wr(1, 8'h1C, 32'h4444_001C, 4'hF, 1'b1);
    rd(1, 8'h10, 1'b1);
    rd(1, 8'h14, 1'b1);
    rd(1, 8'h18, 1'b1);
    rd(1, 8'h1C, 1'b1);
    wr(1, 8'h20, 32'h7777_0020, 4'b1001, 1'b1);
    rd(1, 8'h20, 1'b0);

    wr(2, 8'h08, 32'h1234_5678, 4'hF, 1'b0);
    psel_v[2]    = 1'b1;
    penable_v[2] = 1'b0;
    pwrite_v[2]  = 1'b1;
    paddr_a[2]   = 8'h08;
    pwdata_a[2]  = 32'hCAFE_F00D;
    pstrb_a[2]   = 4'hF;
    @(posedge clk); #1;
    penable_v[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_pre_rdy", 64'(pready_v[2]), 64'h1);
    rst_n_v[2]   = 1'b0;
    psel_v[2]    = 1'b0;
    penable_v[2] = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_pready", 64'(pready_v[2]), 64'h0);
    chk("mid_rst_pslverr", 64'(pslverr_v[2]), 64'h0);
    chk("mid_rst_prdata", 64'(prdata_a[2]), 64'h0);
    rst_n_v[2] = 1'b1;
    for (int i = 0; i < NR; i++) model[2][i] = '0;
    rd(2, 8'h08, 1'b0);
    rd(2, 8'h0C, 1'b0);

    chk("sb_empty", 64'(sbq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Parametrised APB slave register file, successor to the fixed-width APB slave DUT in the APB UVC testbench. It adds separate write/read data buses, byte strobes, a configurable register count and programmable wait states. It also adds PSLVERR reporting for misaligned or out-of-range accesses. It sits under the hardware top as the DUT driven by the APB interface.

## Interface
- DATA_WIDTH, 32: data bus width in bits; multiple of 8, 8..64.
- ADDR_WIDTH, 8: byte-address width of paddr.
- NUM_REGS, 16: number of DATA_WIDTH registers; 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 0: extra ACCESS cycles inserted before pready; 0..15.

Ports:
- pclk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- psel  in  1  slave select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte enables; ignored on reads.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response; valid only while pready = 1.

## Operation
- Address decode:
  - Byte-lane bits = log2(DATA_WIDTH/8).
  - Register index = paddr >> byte-lane bits.
  - The access is an error if any byte-lane bit is nonzero or index >= NUM_REGS.
- Address, direction, data and strobes are sampled at the SETUP edge (psel=1, penable=0) and held internally for the transfer.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS unconditionally. The wait counter loads WAIT_STATES.
  - ACCESS with psel=1, penable=1 and counter>0: decrement the counter and stay in ACCESS.
  - ACCESS with counter=0: pready=1 and the transfer completes at the next edge.
  - After completion: -> SETUP if psel=1 and penable=0 (back-to-back), else -> IDLE.
  - ACCESS with psel=0 or penable=0 before completion is a protocol abort: -> IDLE, no register update, no pready.
- Write completion with no error:
  - Each byte lane i with pstrb[i]=1 is written from pwdata.
  - Lanes with pstrb[i]=0 keep their value.
  - pstrb=0 is a legal no-op with pslverr=0.
- Write with error: no register changes; pslverr=1 with pready.
- Read completion: prdata = register[index]; prdata = 0 when pslverr=1.
- prdata is 0 in every cycle where pready=0.

## Timing
- Reset values:
  - All registers 0, FSM in IDLE, wait counter 0.
  - pready=0, pslverr=0, prdata=0.
- pready, pslverr and prdata are decoded combinationally from registered state only (counter, FSM, captured address, register array). They do not depend combinationally on APB inputs in the same cycle.
- Latency, SETUP to completion: 2 + WAIT_STATES cycles. With WAIT_STATES=0, pready=1 in the first ACCESS cycle.
- pready is high for exactly one cycle per transfer.
- Register update occurs at the rising edge ending the pready=1 cycle. A read of the same register in the immediately following transfer returns the new value.
- Back-to-back transfers: no IDLE cycle is required between completion and the next SETUP.
- Reset asserted mid-transfer at any state:
  - Transfer aborted, no partial write.
  - All outputs take reset values in the cycle after the reset edge.
- Inputs changed by the master during ACCESS are ignored except psel and penable, because they were captured at SETUP.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with psel=1 -> pready=0, pslverr=0, prdata=0; read of index 0 after release returns 0x0000_0000.
- Zero-wait write/read, WAIT_STATES=0: write 0xDEAD_BEEF to paddr 0x08 with pstrb=4'hF -> pready on the 2nd cycle after SETUP; read of 0x08 returns 0xDEAD_BEEF with pslverr=0.
- Byte strobes: register at 0x04 holds 0x1122_3344; write 0xAABB_CCDD with pstrb=4'b0101 -> read returns 0x11BB_33DD.
- Wait states, WAIT_STATES=3: single read -> pready asserts exactly 5 cycles after the SETUP edge and is high for 1 cycle.
- Errors, NUM_REGS=16:
  - Write to 0x40 -> pslverr=1 with pready and no register changes.
  - Read from 0x02 (misaligned) -> pslverr=1 and prdata=0.
- Abort and back-to-back:
  - Drop penable in ACCESS with WAIT_STATES=2 -> no write and FSM returns to IDLE.
  - Then 4 consecutive writes with no IDLE between them -> each completes in 4 cycles and all 4 values read back correctly.
